// File: rtl/clk_meas_pkg.sv
// Shared constants and FSM encoding for the clock period meter.
package clk_meas_pkg;

    localparam int WIDTH_DEF   = 28;
    localparam int TIMEOUT_DEF = 100000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } meas_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser followed by a single-cycle rise/fall detector.
// SYNC_STAGES must be at least 2.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   prev_p1;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            prev_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_in};
            prev_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    // Edge stage: compare the synchronised level against its one-cycle delay
    assign level = sync_p0[SYNC_STAGES-1];
    assign rise  = level & ~prev_p1;
    assign fall  = ~level & prev_p1;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow clock in clock_in cycles, with a
// stall flag when no rising edge arrives within TIMEOUT cycles.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int               WIDTH       = WIDTH_DEF,
    parameter logic [WIDTH-1:0] TIMEOUT     = WIDTH'(TIMEOUT_DEF),
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             meas_valid,
    output logic             stalled
);

    localparam logic [1:0]       ST_IDLE  = IDLE;
    localparam logic [1:0]       ST_ARMED = ARMED;
    localparam logic [1:0]       ST_RUN   = RUN;
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

    logic             level_unused;
    logic             rise;
    logic             fall;
    logic [1:0]       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hi_lat;
    logic             timeout_hit;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock_in(clock_in),
        .reset   (reset),
        .sig_in  (sig_in),
        .level   (level_unused),
        .rise    (rise),
        .fall    (fall)
    );

    // A rise in the same cycle always beats the timeout
    assign timeout_hit = (cnt == TIMEOUT) && !rise;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= WIDTH'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    // Measurement stage: cnt holds the full period on the rise cycle
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            hi_lat     <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_ARMED;
                    end else if (timeout_hit) begin
                        stalled <= 1'b1;
                    end
                end
                ST_ARMED, ST_RUN: begin
                    if (fall) begin
                        hi_lat <= cnt;
                    end
                    if (rise) begin
                        state      <= ST_RUN;
                        period     <= cnt;
                        high_time  <= hi_lat;
                        meas_valid <= 1'b1;
                        stalled    <= 1'b0;
                    end else if (timeout_hit) begin
                        stalled <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: three instances with different TIMEOUT
// values share one clock and reset; each test drives one instance.
module tb_clk_period_meter;

    logic        clock_in;
    logic        reset;
    logic        sig_a, sig_b, sig_c;
    logic [27:0] period_a, period_b, period_c;
    logic [27:0] high_a, high_b, high_c;
    logic        mv_a, mv_b, mv_c;
    logic        st_a, st_b, st_c;

    int n_assert = 0;
    int n_fail   = 0;
    int na = 0, nb = 0, nc = 0, nstc = 0;

    clk_period_meter #(.WIDTH(28), .TIMEOUT(28'd100000), .SYNC_STAGES(2)) dut_a (
        .clock_in(clock_in), .reset(reset), .sig_in(sig_a),
        .period(period_a), .high_time(high_a), .meas_valid(mv_a), .stalled(st_a)
    );

    clk_period_meter #(.WIDTH(28), .TIMEOUT(28'd100), .SYNC_STAGES(2)) dut_b (
        .clock_in(clock_in), .reset(reset), .sig_in(sig_b),
        .period(period_b), .high_time(high_b), .meas_valid(mv_b), .stalled(st_b)
    );

    clk_period_meter #(.WIDTH(28), .TIMEOUT(28'd10), .SYNC_STAGES(2)) dut_c (
        .clock_in(clock_in), .reset(reset), .sig_in(sig_c),
        .period(period_c), .high_time(high_c), .meas_valid(mv_c), .stalled(st_c)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply input levels, step one clock, sample 1ns after the edge.
    task automatic drive(input logic a, input logic b, input logic c);
        sig_a = a;
        sig_b = b;
        sig_c = c;
        @(posedge clock_in);
        #1;
        if (mv_a) na++;
        if (mv_b) nb++;
        if (mv_c) nc++;
        if (st_c) nstc++;
    endtask

    task automatic do_reset();
        sig_a = 1'b0;
        sig_b = 1'b0;
        sig_c = 1'b0;
        reset = 1'b1;
        @(posedge clock_in);
        @(posedge clock_in);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int   na0, nb1, nc0, nstc0;
        logic v;

        // Reset held with the input toggling
        reset = 1'b1;
        sig_a = 1'b0;
        sig_b = 1'b0;
        sig_c = 1'b0;
        for (int i = 0; i < 6; i++) drive(~sig_a, 1'b0, 1'b0);
        check("rst_period", period_a, 0);
        check("rst_high", high_a, 0);
        check("rst_valid", mv_a, 0);
        check("rst_stalled", st_a, 0);

        // Divider-style: high 2 / low 2
        do_reset();
        na0 = na;
        for (int i = 1; i <= 48; i++) begin
            v = ((i - 1) % 4) < 2;
            drive(v, 1'b0, 1'b0);
            if (i == 6) check("div_no_first_pulse", na - na0, 0);
            if (i == 7) begin
                check("div_valid", mv_a, 1);
                check("div_period", period_a, 4);
                check("div_high", high_a, 2);
            end
            if (i == 8) check("div_single_pulse", mv_a, 0);
        end
        check("div_pulse_count", na - na0, 11);
        check("div_period_end", period_a, 4);

        // Asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        check("async_rst_period", period_a, 0);
        check("async_rst_high", high_a, 0);
        check("async_rst_valid", mv_a, 0);
        check("async_rst_stalled", st_a, 0);

        // Full-size ratio: period 20000, high 10000
        do_reset();
        na0 = na;
        for (int i = 1; i <= 40003; i++) begin
            v = ((i - 1) % 20000) < 10000;
            drive(v, 1'b0, 1'b0);
            if (i == 20002) check("full_no_early", na - na0, 0);
            if (i == 20003) begin
                check("full_valid", mv_a, 1);
                check("full_period", period_a, 20000);
                check("full_high", high_a, 10000);
            end
        end
        check("full_pulse_count", na - na0, 2);
        check("full_period_end", period_a, 20000);
        check("full_high_end", high_a, 10000);
        check("full_stalled", st_a, 0);

        // Asymmetric duty: 3/7 then 7/3
        do_reset();
        for (int i = 1; i <= 33; i++) begin
            if (i <= 20)      v = ((i - 1) % 10) < 3;
            else if (i <= 27) v = 1'b1;
            else if (i <= 30) v = 1'b0;
            else              v = 1'b1;
            drive(v, 1'b0, 1'b0);
            if (i == 23) begin
                check("asym3_valid", mv_a, 1);
                check("asym3_period", period_a, 10);
                check("asym3_high", high_a, 3);
            end
        end
        check("asym7_valid", mv_a, 1);
        check("asym7_period", period_a, 10);
        check("asym7_high", high_a, 7);

        // Timeout (TIMEOUT = 100), then resume
        do_reset();
        nb1 = nb;
        for (int i = 1; i <= 136; i++) begin
            if (i <= 30)       v = ((i - 1) % 10) < 5;
            else if (i <= 123) v = 1'b0;
            else               v = ((i - 124) % 10) < 5;
            drive(1'b0, v, 1'b0);
            if (i == 122) begin
                check("to_not_yet", st_b, 0);
                check("to_period_before", period_b, 10);
            end
            if (i == 123) begin
                check("to_stalled", st_b, 1);
                check("to_period_kept", period_b, 10);
                check("to_high_kept", high_b, 5);
                nb1 = nb;
            end
            if (i == 135) begin
                check("to_resume_no_first", nb - nb1, 0);
                check("to_still_stalled", st_b, 1);
            end
        end
        check("to_resume_valid", mv_b, 1);
        check("to_resume_cleared", st_b, 0);
        check("to_resume_period", period_b, 10);
        check("to_resume_high", high_b, 5);

        // Tie-break (TIMEOUT = 10, period 10)
        do_reset();
        nc0   = nc;
        nstc0 = nstc;
        for (int i = 1; i <= 63; i++) begin
            v = ((i - 1) % 10) < 5;
            drive(1'b0, 1'b0, v);
        end
        check("tie_never_stalled", nstc - nstc0, 0);
        check("tie_pulse_count", nc - nc0, 6);
        check("tie_valid", mv_c, 1);
        check("tie_period", period_c, 10);
        check("tie_high", high_c, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Measures a slow, divided clock (for example the output of the board clock divider) in units of the fast board clock.
- Reports the period and high time of the slow clock so firmware and LEDs can check divider settings.
- Sits beside the divider, on its output.
- `sig_in` is treated as asynchronous to `clock_in` and is synchronised internally.

Parameters:
- `WIDTH`, 28, width of the cycle counter and of the measurement outputs.
- `TIMEOUT`, 28'd100000, number of `clock_in` cycles without a rising edge on `sig_in` before `stalled` is asserted.
- `SYNC_STAGES`, 2, flip-flop stages in the input synchroniser (minimum 2).

Ports:
- `clock_in`  input  1  fast board clock; the only clock.
- `reset`  input  1  asynchronous, active-high reset.
- `sig_in`  input  1  slow clock under measurement.
- `period`  output  WIDTH  `clock_in` cycles between the last two rising edges of `sig_in`.
- `high_time`  output  WIDTH  `clock_in` cycles `sig_in` was high within that period.
- `meas_valid`  output  1  one-cycle pulse when `period` and `high_time` update.
- `stalled`  output  1  no rising edge seen for `TIMEOUT` cycles.

Behaviour:
- **Clocking and reset:** one clock, `clock_in`. Reset is asynchronous and active-high on `reset`. All registers, including the synchroniser, clear on reset.
- **Reset values:**
  - `period` = 0, `high_time` = 0.
  - `meas_valid` = 0, `stalled` = 0.
  - State = IDLE, `cnt` = 0.
- **Input path:** `SYNC_STAGES`-deep synchroniser, then edge detect against a delayed copy.
  - `rise` = sync & ~prev; `fall` = ~sync & prev.
  - Edge-detect latency is `SYNC_STAGES`+1 cycles. It is identical for both edges, so measurements are unaffected.
- **Counter `cnt`:**
  - On a `rise` cycle, `cnt` <= 1.
  - Otherwise `cnt` increments, saturating at 2^WIDTH-1.
  - A rise P cycles after the previous rise therefore sees `cnt` == P.
- **FSM states:** IDLE, ARMED, RUN.
  - IDLE: wait for `rise` -> ARMED. `cnt` is still maintained for the timeout check.
  - ARMED: first rise seen; the period is not yet complete. On `fall`, `hi_lat` <= `cnt`. On `rise` -> RUN and publish.
  - RUN: on `fall`, `hi_lat` <= `cnt`. On `rise`, publish and stay in RUN.
- **Publish, single cycle:**
  - `period` <= `cnt` and `high_time` <= `hi_lat`, both registered.
  - `meas_valid` = 1 in the cycle after the `rise` cycle.
  - `stalled` <= 0.
  - The two outputs are always coherent: both come from the same period.
- **Timeout:** in ARMED or RUN, when `cnt` == `TIMEOUT` and there is no `rise` that cycle:
  - `stalled` <= 1, state -> IDLE.
  - `period` and `high_time` keep their last values.
  - In IDLE, `stalled` also sets when `cnt` reaches `TIMEOUT`.
  - `stalled` stays high until the next publish.
- **Boundary conditions:**
  - `rise` and timeout in the same cycle: `rise` wins.
  - `sig_in` stuck high: no `rise` occurs, so timeout fires.
  - Reset mid-measurement: immediate clear to the reset values; the partial period is discarded.
  - `meas_valid` never asserts for the first, partial period after reset or after a stall.
  - A glitch narrower than one `clock_in` cycle may be missed. Measurement resolution is ±1 cycle for truly asynchronous input.

Decomposition:
- Package `clk_meas_pkg` holds:
  - FSM state enum (IDLE, ARMED, RUN).
  - `WIDTH` default constant.
  - Default `TIMEOUT` constant.
- Sub-module `sync_edge_detect` (parameter `SYNC_STAGES`):
  - Inputs: `clock_in`, `reset`, `sig_in`.
  - Outputs: `level`, `rise`, `fall`.
  - Reusable elsewhere for pushbuttons.

Test Plan:
- **Reset values:** hold `reset` high with `sig_in` toggling -> `period`=0, `high_time`=0, `meas_valid`=0, `stalled`=0. Then assert `reset` mid-cycle -> all outputs clear that same cycle, asynchronously.
- **Divider-style input:** `sig_in` high 2 / low 2 `clock_in` cycles -> no `meas_valid` on the first rise. On the second rise, a single pulse with `period`=4, `high_time`=2. Subsequent pulses repeat every 4 cycles.
- **Full-size ratio:** `sig_in` period 20000, high 10000 -> `period`=20000, `high_time`=10000, `meas_valid` once per 20000 cycles, `stalled`=0.
- **Asymmetric duty:** high 3 / low 7 -> `period`=10, `high_time`=3. Then switch to high 7 / low 3 -> the next publish gives `period`=10, `high_time`=7.
- **Timeout:** `TIMEOUT`=100, `sig_in` running at period 10, then held low -> `stalled`=1 exactly 100 cycles after the last `rise`, `period` unchanged. Resume toggling -> the first rise gives no pulse; the second rise publishes and clears `stalled`.
- **Tie-break:** `TIMEOUT`=10, `sig_in` period exactly 10 -> `stalled` never asserts and `period`=10 every publish.
